// File: rtl/bpsk_demodulator.sv
// bpsk_demodulator
//   Coherent BPSK demodulator. Each accepted sample is multiplied by the
//   aligned local sine reference; the products of one carrier period are
//   summed and the sign of the sum decides the bit. DATA_WIDTH bits are
//   assembled LSB first into a word.
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   en         : sample strobe; inputs are taken only when en=1
//   sample_in  : received sample, signed
//   ref_in     : local sine reference aligned to sample_in, signed
//   cnt_in     : phase index of sample_in within the carrier period
//   data_out   : last recovered word
//   data_valid : one-cycle pulse when data_out/data_err update
//   data_err   : 1 if any bit of the word had a weak correlation
//   locked     : 1 while the phase tracker is in RUN
module bpsk_demodulator #(
  parameter int SAMPLE_NUMBER = 256,
  parameter int SAMPLE_WIDTH  = 12,
  parameter int DATA_WIDTH    = 12,
  parameter int THRESHOLD     = 2**20,
  localparam int CNT_WIDTH    = $clog2(SAMPLE_NUMBER)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  input  logic signed [SAMPLE_WIDTH-1:0] ref_in,
  input  logic [CNT_WIDTH-1:0]           cnt_in,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           data_valid,
  output logic                           data_err,
  output logic                           locked
);

  localparam int PROD_WIDTH = 2 * SAMPLE_WIDTH;
  localparam int ACC_WIDTH  = PROD_WIDTH + CNT_WIDTH;
  localparam int BIT_WIDTH  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [ACC_WIDTH-1:0] THR = ACC_WIDTH'(THRESHOLD);

  typedef enum logic {WAIT_SYNC, RUN} state_t;

  state_t state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_prev_reg;
  logic accept, abort;

  // Phase tracker: in RUN a sample is taken only if its index continues the
  // sequence. A break discards the partial word and the same sample is then
  // judged as a possible sync point (index 0).
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    abort      = 1'b0;
    if (en) begin
      if (state_reg == RUN && cnt_in == cnt_prev_reg + CNT_WIDTH'(1)) begin
        accept = 1'b1;
      end else begin
        abort = (state_reg == RUN);
        if (cnt_in == '0) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = WAIT_SYNC;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= WAIT_SYNC;
      cnt_prev_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) cnt_prev_reg <= cnt_in;
    end
  end

  assign locked = (state_reg == RUN);

  // Stage 1: registered product with bit-boundary flags.
  logic signed [PROD_WIDTH-1:0] prod_next, prod_reg;
  logic prod_valid_reg, prod_first_reg, prod_last_reg;

  assign prod_next = PROD_WIDTH'(sample_in) * PROD_WIDTH'(ref_in);

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_reg       <= '0;
      prod_valid_reg <= 1'b0;
      prod_first_reg <= 1'b0;
      prod_last_reg  <= 1'b0;
    end else begin
      prod_valid_reg <= accept;
      if (accept) begin
        prod_reg       <= prod_next;
        prod_first_reg <= (cnt_in == '0);
        prod_last_reg  <= (cnt_in == CNT_WIDTH'(SAMPLE_NUMBER - 1));
      end
    end
  end

  // Stage 2: accumulate, decide, assemble.
  logic signed [ACC_WIDTH-1:0] acc_reg, sum_next;
  logic [ACC_WIDTH-1:0]        mag_next;
  logic [DATA_WIDTH-1:0]       shift_reg, word_next;
  logic [BIT_WIDTH-1:0]        bit_cnt_reg;
  logic                        weak_reg;
  logic                        decision, weak_bit, bit_done, word_done;
  logic [DATA_WIDTH-1:0]       data_out_reg;
  logic                        data_valid_reg, data_err_reg;

  always_comb begin
    // The first product of a bit restarts the sum instead of adding to it.
    sum_next  = (prod_first_reg ? '0 : acc_reg) + ACC_WIDTH'(prod_reg);
    decision  = ~sum_next[ACC_WIDTH-1] && (sum_next != '0);
    mag_next  = sum_next[ACC_WIDTH-1] ? ACC_WIDTH'(-sum_next) : ACC_WIDTH'(sum_next);
    weak_bit  = (mag_next < THR);
    bit_done  = prod_valid_reg && prod_last_reg;
    word_done = bit_done && (bit_cnt_reg == BIT_WIDTH'(DATA_WIDTH - 1));
    // Shift in from the top so the first bit ends up at bit 0.
    word_next = {decision, shift_reg[DATA_WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg        <= '0;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      weak_reg       <= 1'b0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      data_err_reg   <= 1'b0;
    end else begin
      data_valid_reg <= 1'b0;
      if (prod_valid_reg) acc_reg <= sum_next;
      if (bit_done) begin
        shift_reg <= word_next;
        if (word_done) begin
          bit_cnt_reg    <= '0;
          weak_reg       <= 1'b0;
          data_out_reg   <= word_next;
          data_err_reg   <= weak_reg | weak_bit;
          data_valid_reg <= 1'b1;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + BIT_WIDTH'(1);
          weak_reg    <= weak_reg | weak_bit;
        end
      end
      // A phase break throws away the partial word. A word already completed
      // by the product arriving in the same cycle is still delivered above.
      if (abort) begin
        acc_reg     <= '0;
        shift_reg   <= '0;
        bit_cnt_reg <= '0;
        weak_reg    <= 1'b0;
      end
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign data_err   = data_err_reg;

endmodule

// File: doc/bpsk_demodulator.md
BPSK_DEMODULATOR -- requirements
Module: bpsk_demodulator

Interface
REQ-001 SHALL have parameter SAMPLE_NUMBER, default 256, samples per carrier period (one bit), power of two.
REQ-002 SHALL have parameter SAMPLE_WIDTH, default 12, width of sample and reference, two's complement.
REQ-003 SHALL have parameter DATA_WIDTH, default 12, bits per recovered word.
REQ-004 SHALL have parameter THRESHOLD, default 2**20, minimum per-bit correlation magnitude for a confident decision.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port en  input  1  sample strobe; inputs are accepted only in cycles with en=1.
REQ-008 SHALL have port sample_in  input  SAMPLE_WIDTH  received BPSK sample, signed.
REQ-009 SHALL have port ref_in  input  SAMPLE_WIDTH  local sine reference aligned to sample_in, signed.
REQ-010 SHALL have port cnt_in  input  clog2(SAMPLE_NUMBER)  phase index of the current sample within the carrier period.
REQ-011 SHALL have port data_out  output  DATA_WIDTH  last recovered word.
REQ-012 SHALL have port data_valid  output  1  one-cycle pulse when data_out updates.
REQ-013 SHALL have port data_err  output  1  qualifies data_out; 1 if any bit of the word was below THRESHOLD.
REQ-014 SHALL have port locked  output  1  1 while in RUN state.

Function
REQ-015 SHALL implement states WAIT_SYNC and RUN; reset state is WAIT_SYNC.
REQ-016 WAIT_SYNC: accepted samples with cnt_in != 0 are discarded; accepted sample with cnt_in == 0 is the first sample of bit 0 of a new word, and the FSM moves to RUN.
REQ-017 RUN: each accepted sample's cnt_in SHALL equal previous accepted cnt_in + 1 modulo SAMPLE_NUMBER; on mismatch, partial word and accumulator are discarded, no data_valid, FSM returns to WAIT_SYNC and the mismatching sample is re-evaluated under REQ-016 in the same cycle.
REQ-018 Stage 1: each accepted sample produces registered signed product sample_in*ref_in (2*SAMPLE_WIDTH bits) plus a last flag (cnt_in == SAMPLE_NUMBER-1), one cycle after acceptance.
REQ-019 Stage 2: signed accumulator of width 2*SAMPLE_WIDTH+clog2(SAMPLE_NUMBER) sums products; no overflow possible; cleared at the start of each bit.
REQ-020 On a last-flagged product, bit decision = 1 if final sum > 0, else 0 (sum == 0 decides 0); bit is weak if |sum| < THRESHOLD.
REQ-021 Bits are assembled LSB first: first bit of a word is data_out[0], DATA_WIDTH-th bit is data_out[DATA_WIDTH-1].
REQ-022 After the DATA_WIDTH-th decision, data_out, data_err update and data_valid pulses exactly 2 cycles after acceptance of that bit's cnt_in == SAMPLE_NUMBER-1 sample; bit counter wraps to 0 and the next word starts without re-sync.
REQ-023 data_err = OR of weak flags over the word's bits; weak flags clear per word.
REQ-024 en=0 cycles do not advance state, counters or accumulator; in-flight stage-1 products still complete; gaps of any length do not break lock.
REQ-025 data_out and data_err hold between data_valid pulses.

Reset
REQ-026 rst=1 at a clock edge SHALL set data_out=0, data_valid=0, data_err=0, locked=0, accumulator, products, bit counter, weak flags cleared, FSM to WAIT_SYNC, regardless of mid-word position; rst dominates en.

Verification
REQ-027 Reset, then feed ideal modulated waveform (full-scale sine, +sin for 1, -sin for 0) for word 12'hA5C, cnt_in 0..255 continuous -> one data_valid pulse, data_out=12'hA5C, data_err=0, 2 cycles after last sample.
REQ-028 Start stream at cnt_in=100 -> samples ignored, locked=0 until cnt_in=0, then word decoded correctly from that point.
REQ-029 All-zero samples for one word -> data_out=12'h000, data_err=1.
REQ-030 Random en=0 gaps (1-7 cycles) inside word 12'h3C1 -> data_out=12'h3C1, data_err=0.
REQ-031 cnt_in jumps 40->45 mid-word -> no data_valid for that word, locked drops to 0, next aligned word decodes correctly.
REQ-032 rst pulse mid-word 6 -> outputs zero next cycle, partial word never emitted, subsequent word decodes correctly.
